fetch_stage: RTL and testbench

- Instruction fetch front end that sits directly upstream of the instruction memory and directly downstream of it toward decode.
- Owns the program counter and drives it to the instruction memory as a byte address.
- Captures the returned 32-bit instruction word with its PC into a small FIFO.
- Presents the FIFO head to the decode stage over a valid/ready handshake, with stall handling and branch-redirect flush.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, captures {pc, instr} pairs from the
// instruction memory into a small FIFO and presents the head to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] PC_LIMIT   = 32'd24,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic [31:0]                 fetch_pc,
    input  logic [31:0]                 fetch_instr,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [31:0]                 dec_instr,
    output logic [31:0]                 dec_pc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc;
    logic [31:0]   pc_q    [FIFO_DEPTH];
    logic [31:0]   instr_q [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          full;
    logic          pop;
    logic          push;
    logic [31:0]   pc_inc;
    logic [31:0]   next_pc;
    logic [31:0]   redirect_aligned;
    logic [31:0]   redirect_target;

    assign full             = (count == CW'(FIFO_DEPTH));
    assign pop              = dec_valid & dec_ready;
    assign push             = enable & ~redirect_valid & (~full | pop);
    assign pc_inc           = pc + 32'd4;
    assign next_pc          = (pc_inc >= PC_LIMIT) ? RESET_PC : pc_inc;
    assign redirect_aligned = redirect_pc & ~32'h3;
    assign redirect_target  = (redirect_aligned >= PC_LIMIT) ? RESET_PC : redirect_aligned;

    // Redirect outranks push and pop: a same-cycle pop is dropped with the flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc    <= redirect_target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_q[tail]    <= pc;
                instr_q[tail] <= fetch_instr;
                tail          <= tail + PW'(1);
                pc            <= next_pc;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign fetch_pc   = pc;
    assign dec_valid  = (count != '0);
    assign dec_instr  = instr_q[head];
    assign dec_pc     = pc_q[head];
    assign fifo_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based scoreboard of fetched entries plus a
// redirect vector table and hand-written backpressure/enable/reset sequences.
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [1:0]  fifo_count;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fifo_count     (fifo_count)
    );

    logic [31:0] img [6];

    function automatic logic [31:0] img_at(input logic [31:0] a);
        if (a < 32'd24) return img[a[4:2]];
        return 32'h0;
    endfunction

    always_comb fetch_instr = img_at(fetch_pc);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } redir_vec_t;

    entry_t      model_q [$];
    logic [31:0] popped [$];
    logic [31:0] m_pc;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One clock: compare head against the scoreboard, predict, clock, compare state.
    task automatic cycle();
        logic        m_pop;
        logic        m_push;
        logic        rst_edge;
        logic [31:0] a;
        if (model_q.size() != 0) begin
            check("head_pc", dec_pc, model_q[0].pc);
            check("head_instr", dec_instr, model_q[0].instr);
        end
        m_pop  = (model_q.size() != 0) && dec_ready;
        m_push = enable && !redirect_valid && ((model_q.size() < 2) || m_pop);
        if (reset && !redirect_valid && m_pop) popped.push_back(dec_pc);
        rst_edge = !reset;
        @(posedge clock);
        if (rst_edge) begin
            model_q.delete();
            m_pc = 32'h0;
        end else if (redirect_valid) begin
            model_q.delete();
            a    = redirect_pc & ~32'h3;
            m_pc = (a >= 32'd24) ? 32'h0 : a;
        end else begin
            if (m_pop) void'(model_q.pop_front());
            if (m_push) begin
                model_q.push_back({m_pc, img_at(m_pc)});
                m_pc = (m_pc + 32'd4 >= 32'd24) ? 32'h0 : m_pc + 32'd4;
            end
        end
        #1;
        check("fetch_pc", fetch_pc, m_pc);
        check("fifo_count", 32'(fifo_count), model_q.size());
        check("dec_valid", 32'(dec_valid), 32'(model_q.size() != 0));
        if (rst_edge) begin
            check("rst_dec_instr", dec_instr, 32'h0);
            check("rst_dec_pc", dec_pc, 32'h0);
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    redir_vec_t vecs [7];

    initial begin
        logic [31:0] exp_stream [7];
        img[0] = 32'h00940333; img[1] = 32'h412983b3; img[2] = 32'h00f768b3;
        img[3] = 32'h00d67fb3; img[4] = 32'h017b4e33; img[5] = 32'h01bdaf33;
        vecs[0] = '{32'd12,       1'b0, 32'd12,   32'h00d67fb3};
        vecs[1] = '{32'h11,       1'b0, 32'h10,   32'h017b4e33};
        vecs[2] = '{32'd28,       1'b0, 32'h0,    32'h00940333};
        vecs[3] = '{32'h17,       1'b1, 32'h14,   32'h01bdaf33};
        vecs[4] = '{32'd24,       1'b1, 32'h0,    32'h00940333};
        vecs[5] = '{32'hFFFFFFFE, 1'b0, 32'h0,    32'h00940333};
        vecs[6] = '{32'd6,        1'b0, 32'd4,    32'h412983b3};
        exp_stream = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd0};
        m_pc = 32'h0;

        // Reset, then stream with decode always ready.
        reset = 1'b0; enable = 1'b1; dec_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        run(2);
        reset = 1'b1;
        check("valid_before_fetch", 32'(dec_valid), 32'h0);
        popped.delete();
        cycle();
        check("valid_latency", 32'(dec_valid), 32'h1);
        check("first_instr", dec_instr, 32'h00940333);
        run(7);
        check("stream_len", popped.size() >= 7 ? 32'd7 : popped.size(), 32'd7);
        for (int i = 0; i < 7 && i < popped.size(); i++)
            check($sformatf("stream_pc[%0d]", i), popped[i], exp_stream[i]);

        // Backpressure from reset.
        reset = 1'b0;
        run(2);
        reset = 1'b1; dec_ready = 1'b0;
        run(7);
        check("bp_fetch_pc", fetch_pc, 32'd8);
        check("bp_count", 32'(fifo_count), 32'd2);
        check("bp_head_pc", dec_pc, 32'd0);
        check("bp_head_instr", dec_instr, 32'h00940333);
        popped.delete();
        dec_ready = 1'b1;
        cycle();
        check("full_pushpop_count", 32'(fifo_count), 32'd2);
        check("full_pushpop_pc", fetch_pc, 32'd12);
        dec_ready = 1'b0;
        cycle();
        dec_ready = 1'b1;
        run(2);
        check("bp_drain_len", popped.size() >= 3 ? 32'd3 : popped.size(), 32'd3);
        for (int i = 0; i < 3 && i < popped.size(); i++)
            check($sformatf("bp_drain_pc[%0d]", i), popped[i], 32'(i * 4));

        // Redirect vectors, each issued against a full FIFO.
        for (int v = 0; v < 7; v++) begin
            dec_ready = 1'b0; enable = 1'b1;
            run(2);
            redirect_valid = 1'b1; redirect_pc = vecs[v].rpc; dec_ready = vecs[v].rdy;
            cycle();
            check($sformatf("redir%0d_pc", v), fetch_pc, vecs[v].exp_pc);
            check($sformatf("redir%0d_count", v), 32'(fifo_count), 32'd0);
            check($sformatf("redir%0d_valid", v), 32'(dec_valid), 32'd0);
            redirect_valid = 1'b0; dec_ready = 1'b0;
            cycle();
            check($sformatf("redir%0d_head_pc", v), dec_pc, vecs[v].exp_pc);
            check($sformatf("redir%0d_head_instr", v), dec_instr, vecs[v].exp_instr);
        end

        // enable=0 mid-stream: PC freezes and the FIFO drains.
        redirect_valid = 1'b1; redirect_pc = 32'd4; dec_ready = 1'b0;
        cycle();
        redirect_valid = 1'b0;
        run(2);
        enable = 1'b0; dec_ready = 1'b1;
        run(4);
        check("hold_fetch_pc", fetch_pc, 32'd12);
        check("hold_count", 32'(fifo_count), 32'd0);
        check("hold_valid", 32'(dec_valid), 32'd0);

        // Reset with a concurrent redirect.
        enable = 1'b1; dec_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        cycle();
        redirect_valid = 1'b0;
        run(2);
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd16;
        cycle();
        check("rst_redir_pc", fetch_pc, 32'd0);
        check("rst_redir_count", 32'(fifo_count), 32'd0);
        check("rst_redir_valid", 32'(dec_valid), 32'd0);
        check("rst_redir_instr", dec_instr, 32'd0);
        reset = 1'b1; redirect_valid = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
